// File: rtl/fpio_stream_pkg.sv
// Shared constants for the FIFO I/O stream controller: host register map,
// CTRL bit positions and the STATUS vector layout.
package fpio_stream_pkg;

  localparam int A_TXDATA  = 0;
  localparam int A_TXFREE  = 1;
  localparam int A_RXDATA  = 2;
  localparam int A_RXCOUNT = 3;
  localparam int A_CTRL    = 4;
  localparam int A_DIVISOR = 5;
  localparam int A_STATUS  = 6;
  localparam int A_IRQEN   = 7;
  localparam int A_TXTHR   = 8;
  localparam int A_RXTHR   = 9;

  localparam int CTRL_TX_EN    = 0;
  localparam int CTRL_RX_EN    = 1;
  localparam int CTRL_TX_FLUSH = 2;
  localparam int CTRL_RX_FLUSH = 3;

  localparam int ST_TX_OVF = 0;
  localparam int ST_RX_UNF = 1;

  // Low two bits are sticky error flags, upper two are live threshold levels.
  typedef struct packed {
    logic rx_high;
    logic tx_low;
    logic rx_unf;
    logic tx_ovf;
  } status_t;

endpackage

// File: rtl/fpio_sync_fifo.sv
// First-word-fall-through synchronous FIFO with flush; a push into a full
// FIFO or a pop from an empty one is ignored.
module fpio_sync_fifo #(
  parameter int FIFO_BITS  = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [FIFO_BITS:0]    count,
  output logic                  full,
  output logic                  empty
);
  localparam int DEPTH = 1 << FIFO_BITS;
  localparam logic [FIFO_BITS:0] FULL_CNT = (FIFO_BITS+1)'(DEPTH);
  localparam logic [FIFO_BITS:0] ONE      = (FIFO_BITS+1)'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [FIFO_BITS:0]    wr_ptr;
  logic [FIFO_BITS:0]    rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  // Pointers carry one extra wrap bit so the difference is the occupancy.
  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[FIFO_BITS-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ONE;
      if (do_pop)  rd_ptr <= rd_ptr + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[FIFO_BITS-1:0]] <= wdata;
  end

endmodule

// File: rtl/fpio_stream_ctrl.sv
// Host-programmable bridge between a word-addressed register bus and paced
// outbound / inbound valid-ready streams, with error flags and interrupts.
module fpio_stream_ctrl
  import fpio_stream_pkg::*;
#(
  parameter int FIFO_BITS  = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  output logic                  irq,
  input  logic [ADDR_BITS-1:0]  host_addr,
  input  logic                  host_write_en,
  input  logic [31:0]           host_write_data,
  input  logic                  host_read_en,
  output logic [31:0]           host_read_data,
  output logic [DATA_WIDTH-1:0] dat_o_data,
  output logic                  dat_o_valid,
  input  logic                  dat_o_ready,
  input  logic [DATA_WIDTH-1:0] dat_i_data,
  input  logic                  dat_i_valid,
  output logic                  dat_i_ready
);
  localparam int DEPTH = 1 << FIFO_BITS;
  typedef logic [FIFO_BITS:0]   cnt_t;
  typedef logic [ADDR_BITS-1:0] addr_t;

  logic        tx_en;
  logic        rx_en;
  logic [15:0] divisor;
  logic [15:0] pace_cnt;
  logic        tx_ovf;
  logic        rx_unf;
  logic [3:0]  irq_en;
  cnt_t        tx_thr;
  cnt_t        rx_thr;

  cnt_t                  tx_count;
  cnt_t                  rx_count;
  logic                  tx_full, tx_empty, rx_full, rx_empty;
  logic [DATA_WIDTH-1:0] rx_head;
  status_t               status;

  logic wr_txdata, wr_ctrl, wr_div, wr_status, wr_irqen, wr_txthr, wr_rxthr;
  logic rd_rxdata;
  logic tx_pop, tx_flush, rx_push, rx_pop, rx_flush;
  logic tx_ovf_set, rx_unf_set, tx_ovf_clr, rx_unf_clr;
  logic unused_wdata;

  assign wr_txdata = host_write_en && (host_addr == addr_t'(A_TXDATA));
  assign wr_ctrl   = host_write_en && (host_addr == addr_t'(A_CTRL));
  assign wr_div    = host_write_en && (host_addr == addr_t'(A_DIVISOR));
  assign wr_status = host_write_en && (host_addr == addr_t'(A_STATUS));
  assign wr_irqen  = host_write_en && (host_addr == addr_t'(A_IRQEN));
  assign wr_txthr  = host_write_en && (host_addr == addr_t'(A_TXTHR));
  assign wr_rxthr  = host_write_en && (host_addr == addr_t'(A_RXTHR));
  assign rd_rxdata = host_read_en  && (host_addr == addr_t'(A_RXDATA));

  assign tx_flush    = wr_ctrl && host_write_data[CTRL_TX_FLUSH];
  assign rx_flush    = wr_ctrl && host_write_data[CTRL_RX_FLUSH];
  assign dat_o_valid = tx_en && !tx_empty && (pace_cnt == 16'd0);
  assign tx_pop      = dat_o_valid && dat_o_ready;
  assign dat_i_ready = rx_en && !rx_full;
  assign rx_push     = dat_i_valid && dat_i_ready;
  assign rx_pop      = rd_rxdata && !rx_empty;

  // Errors are judged on pre-edge full/empty; a set beats a same-cycle clear.
  assign tx_ovf_set = wr_txdata && tx_full;
  assign rx_unf_set = rd_rxdata && rx_empty;
  assign tx_ovf_clr = wr_status && host_write_data[ST_TX_OVF];
  assign rx_unf_clr = wr_status && host_write_data[ST_RX_UNF];

  assign status.tx_ovf  = tx_ovf;
  assign status.rx_unf  = rx_unf;
  assign status.tx_low  = (tx_count <= tx_thr);
  assign status.rx_high = (rx_count >= rx_thr);

  assign unused_wdata = ^host_write_data;

  fpio_sync_fifo #(.FIFO_BITS(FIFO_BITS), .DATA_WIDTH(DATA_WIDTH)) u_tx_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (wr_txdata),
    .pop   (tx_pop),
    .flush (tx_flush),
    .wdata (host_write_data[DATA_WIDTH-1:0]),
    .rdata (dat_o_data),
    .count (tx_count),
    .full  (tx_full),
    .empty (tx_empty)
  );

  fpio_sync_fifo #(.FIFO_BITS(FIFO_BITS), .DATA_WIDTH(DATA_WIDTH)) u_rx_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (rx_push),
    .pop   (rx_pop),
    .flush (rx_flush),
    .wdata (dat_i_data),
    .rdata (rx_head),
    .count (rx_count),
    .full  (rx_full),
    .empty (rx_empty)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_en    <= 1'b0;
      rx_en    <= 1'b0;
      divisor  <= '0;
      pace_cnt <= '0;
      tx_ovf   <= 1'b0;
      rx_unf   <= 1'b0;
      irq_en   <= '0;
      tx_thr   <= '0;
      rx_thr   <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        tx_en <= host_write_data[CTRL_TX_EN];
        rx_en <= host_write_data[CTRL_RX_EN];
      end
      if (wr_div)   divisor <= host_write_data[15:0];
      if (wr_irqen) irq_en  <= host_write_data[3:0];
      if (wr_txthr) tx_thr  <= host_write_data[FIFO_BITS:0];
      if (wr_rxthr) rx_thr  <= host_write_data[FIFO_BITS:0];

      tx_ovf <= tx_ovf_set || (tx_ovf && !tx_ovf_clr);
      rx_unf <= rx_unf_set || (rx_unf && !rx_unf_clr);
      irq    <= |(status & irq_en);

      // Each accepted beat reloads the gap; a flush abandons any countdown.
      if (tx_flush)              pace_cnt <= '0;
      else if (tx_pop)           pace_cnt <= divisor;
      else if (pace_cnt != '0)   pace_cnt <= pace_cnt - 16'd1;
    end
  end

  always_comb begin
    host_read_data = '0;
    case (host_addr)
      addr_t'(A_TXFREE):  host_read_data = 32'(cnt_t'(DEPTH) - tx_count);
      addr_t'(A_RXDATA):  host_read_data = rx_empty ? 32'd0 : 32'(rx_head);
      addr_t'(A_RXCOUNT): host_read_data = 32'(rx_count);
      addr_t'(A_CTRL):    host_read_data = {30'd0, rx_en, tx_en};
      addr_t'(A_DIVISOR): host_read_data = {16'd0, divisor};
      addr_t'(A_STATUS):  host_read_data = {28'd0, status};
      addr_t'(A_IRQEN):   host_read_data = {28'd0, irq_en};
      addr_t'(A_TXTHR):   host_read_data = 32'(tx_thr);
      addr_t'(A_RXTHR):   host_read_data = 32'(rx_thr);
      default:            host_read_data = '0;
    endcase
  end

endmodule

// File: tb/tb_fpio_stream_ctrl.sv
// Bench for fpio_stream_ctrl: directed scenarios plus random traffic, all
// checked cycle by cycle against a queue-based reference model.
module tb_fpio_stream_ctrl;
  localparam int FB    = 2;
  localparam int DW    = 8;
  localparam int AB    = 4;
  localparam int DEPTH = 1 << FB;

  localparam int R_TXDATA = 0, R_TXFREE = 1, R_RXDATA = 2, R_RXCOUNT = 3, R_CTRL = 4;
  localparam int R_DIV = 5, R_STATUS = 6, R_IRQEN = 7, R_TXTHR = 8, R_RXTHR = 9;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          irq;
  logic [AB-1:0] host_addr = '0;
  logic          host_write_en = 1'b0;
  logic          host_read_en = 1'b0;
  logic [31:0]   host_write_data = '0;
  logic [31:0]   host_read_data;
  logic [DW-1:0] dat_o_data;
  logic          dat_o_valid;
  logic          dat_o_ready = 1'b0;
  logic [DW-1:0] dat_i_data = '0;
  logic          dat_i_valid = 1'b0;
  logic          dat_i_ready;

  always #5 clk = ~clk;

  fpio_stream_ctrl #(.FIFO_BITS(FB), .DATA_WIDTH(DW), .ADDR_BITS(AB)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .irq             (irq),
    .host_addr       (host_addr),
    .host_write_en   (host_write_en),
    .host_write_data (host_write_data),
    .host_read_en    (host_read_en),
    .host_read_data  (host_read_data),
    .dat_o_data      (dat_o_data),
    .dat_o_valid     (dat_o_valid),
    .dat_o_ready     (dat_o_ready),
    .dat_i_data      (dat_i_data),
    .dat_i_valid     (dat_i_valid),
    .dat_i_ready     (dat_i_ready)
  );

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int beat_cyc[$];

  logic          s_ivalid = 1'b0;
  logic          s_oready = 1'b0;
  logic [DW-1:0] s_idata = '0;

  // Reference model state
  logic [DW-1:0] txq[$];
  logic [DW-1:0] rxq[$];
  bit            m_tx_en, m_rx_en, m_irq;
  int            m_div, m_pace, m_txthr, m_rxthr;
  bit [1:0]      m_err;
  bit [3:0]      m_irqen;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  function automatic void model_reset();
    txq.delete();
    rxq.delete();
    m_tx_en = 0; m_rx_en = 0; m_irq = 0;
    m_div = 0; m_pace = 0; m_txthr = 0; m_rxthr = 0;
    m_err = '0; m_irqen = '0;
  endfunction

  function automatic logic [3:0] model_status();
    return {bit'(rxq.size() >= m_rxthr), bit'(txq.size() <= m_txthr), m_err};
  endfunction

  function automatic logic [31:0] model_read(int a);
    case (a)
      R_TXFREE:  return 32'(DEPTH - txq.size());
      R_RXDATA:  return (rxq.size() > 0) ? 32'(rxq[0]) : 32'd0;
      R_RXCOUNT: return 32'(rxq.size());
      R_CTRL:    return {30'd0, m_rx_en, m_tx_en};
      R_DIV:     return 32'(m_div);
      R_STATUS:  return {28'd0, model_status()};
      R_IRQEN:   return {28'd0, m_irqen};
      R_TXTHR:   return 32'(m_txthr);
      R_RXTHR:   return 32'(m_rxthr);
      default:   return 32'd0;
    endcase
  endfunction

  // One clock: drive at negedge, check just after, advance model at posedge.
  task automatic cyc(bit we, bit re, int addr, logic [31:0] wd);
    bit         ov, tx_pop, rx_push;
    int         txn, rxn;
    logic [3:0] st;
    bit [1:0]   nerr;
    @(negedge clk);
    host_write_en   = we;
    host_read_en    = re;
    host_addr       = AB'(addr);
    host_write_data = wd;
    dat_i_valid     = s_ivalid;
    dat_i_data      = s_idata;
    dat_o_ready     = s_oready;
    #1;
    txn = txq.size();
    rxn = rxq.size();
    ov  = m_tx_en && txn > 0 && m_pace == 0;
    check("o_valid", 32'(dat_o_valid), 32'(ov));
    if (ov) check("o_data", 32'(dat_o_data), 32'(txq[0]));
    check("i_ready", 32'(dat_i_ready), 32'(m_rx_en && rxn < DEPTH));
    check("irq", 32'(irq), 32'(m_irq));
    check($sformatf("read_a%0d", addr), host_read_data, model_read(addr));
    if (dat_o_valid && dat_o_ready) beat_cyc.push_back(cycle);
    @(posedge clk);
    cycle++;
    st      = model_status();
    tx_pop  = ov && s_oready;
    rx_push = s_ivalid && m_rx_en && rxn < DEPTH;
    nerr    = m_err;
    if (we && addr == R_STATUS) nerr = nerr & ~wd[1:0];
    if (tx_pop) void'(txq.pop_front());
    if (we && addr == R_TXDATA) begin
      if (txn == DEPTH) nerr[0] = 1'b1;
      else txq.push_back(wd[DW-1:0]);
    end
    if (re && addr == R_RXDATA) begin
      if (rxn == 0) nerr[1] = 1'b1;
      else void'(rxq.pop_front());
    end
    if (rx_push) rxq.push_back(s_idata);
    if (we && addr == R_CTRL && wd[2]) txq.delete();
    if (we && addr == R_CTRL && wd[3]) rxq.delete();
    if (we && addr == R_CTRL && wd[2]) m_pace = 0;
    else if (tx_pop)                   m_pace = m_div;
    else if (m_pace > 0)               m_pace--;
    m_irq = |(st & m_irqen);
    m_err = nerr;
    if (we) begin
      case (addr)
        R_CTRL:  begin m_tx_en = wd[0]; m_rx_en = wd[1]; end
        R_DIV:   m_div   = int'(wd[15:0]);
        R_IRQEN: m_irqen = wd[3:0];
        R_TXTHR: m_txthr = int'(wd[FB:0]);
        R_RXTHR: m_rxthr = int'(wd[FB:0]);
        default: ;
      endcase
    end
  endtask

  task automatic wr(int a, logic [31:0] d); cyc(1'b1, 1'b0, a, d); endtask
  task automatic rd(int a);                 cyc(1'b0, 1'b1, a, 32'd0); endtask
  task automatic peek(int a);               cyc(1'b0, 1'b0, a, 32'd0); endtask
  task automatic idle(int n);               repeat (n) cyc(1'b0, 1'b0, R_TXFREE, 32'd0); endtask

  task automatic apply_reset();
    host_write_en = 1'b0; host_read_en = 1'b0; host_addr = '0; host_write_data = '0;
    dat_i_valid = 1'b0; dat_i_data = '0; dat_o_ready = 1'b0;
    s_ivalid = 1'b0; s_oready = 1'b0; s_idata = '0;
    rstn = 1'b0;
    #1;
    check("rst_o_valid", 32'(dat_o_valid), 32'd0);
    check("rst_i_ready", 32'(dat_i_ready), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic check_gaps(string tag, int n, int gap);
    check({tag, "_beats"}, 32'(beat_cyc.size()), 32'(n));
    for (int i = 1; i < n && i < beat_cyc.size(); i++)
      check({tag, "_gap"}, 32'(beat_cyc[i] - beat_cyc[i-1]), 32'(gap));
  endtask

  initial begin
    int        a, kind;
    logic [31:0] wd;
    #2;
    apply_reset();
    for (int i = 0; i < 12; i++) peek(i);

    // Back-to-back outbound
    wr(R_DIV, 0);
    wr(R_CTRL, 1);
    wr(R_TXDATA, 32'h11); wr(R_TXDATA, 32'h22); wr(R_TXDATA, 32'h33);
    beat_cyc.delete();
    s_oready = 1'b1;
    idle(5);
    check_gaps("b2b", 3, 1);
    peek(R_TXFREE);

    // Paced outbound, then divisor dropped mid-stream
    wr(R_CTRL, 0);
    wr(R_DIV, 3);
    for (int i = 0; i < 4; i++) wr(R_TXDATA, 32'h40 + 32'(i));
    beat_cyc.delete();
    wr(R_CTRL, 1);
    idle(16);
    check_gaps("pace", 4, 4);
    for (int i = 0; i < 4; i++) wr(R_TXDATA, 32'h50 + 32'(i));
    wr(R_DIV, 0);
    idle(8);

    // Outbound overflow and W1C
    s_oready = 1'b0;
    wr(R_CTRL, 0);
    for (int i = 0; i < 5; i++) wr(R_TXDATA, 32'hA0 + 32'(i));
    peek(R_TXFREE);
    peek(R_STATUS);
    wr(R_STATUS, 1);
    peek(R_STATUS);
    s_oready = 1'b1;
    wr(R_CTRL, 1);
    idle(6);

    // Inbound path, underflow, full back-pressure
    wr(R_CTRL, 2);
    s_ivalid = 1'b1; s_idata = 8'hA5; peek(R_RXCOUNT);
    s_idata = 8'h5A; peek(R_RXCOUNT);
    s_ivalid = 1'b0;
    peek(R_RXCOUNT);
    rd(R_RXDATA); rd(R_RXDATA); rd(R_RXDATA);
    peek(R_STATUS);
    wr(R_STATUS, 2);
    s_ivalid = 1'b1;
    for (int i = 0; i < 6; i++) begin s_idata = 8'(i + 1); peek(R_RXCOUNT); end
    s_ivalid = 1'b0;
    for (int i = 0; i < 4; i++) rd(R_RXDATA);

    // Threshold interrupts
    wr(R_RXTHR, 2);
    wr(R_IRQEN, 8);
    s_ivalid = 1'b1; s_idata = 8'h01; peek(R_STATUS);
    s_idata = 8'h02; peek(R_STATUS);
    s_ivalid = 1'b0;
    idle(2);
    rd(R_RXDATA); rd(R_RXDATA);
    idle(2);
    wr(R_TXTHR, 0);
    wr(R_IRQEN, 4);
    s_oready = 1'b0;
    wr(R_CTRL, 1);
    wr(R_TXDATA, 32'h77); wr(R_TXDATA, 32'h88);
    s_oready = 1'b1;
    idle(5);

    // Flush during a pacing countdown
    wr(R_IRQEN, 0);
    wr(R_DIV, 5);
    for (int i = 0; i < 3; i++) wr(R_TXDATA, 32'hC0 + 32'(i));
    wr(R_CTRL, 32'h5);
    beat_cyc.delete();
    idle(8);
    check("flush_no_beats", 32'(beat_cyc.size()), 32'd0);
    peek(R_TXFREE);

    // Asynchronous reset in the middle of streaming
    wr(R_DIV, 0);
    wr(R_IRQEN, 32'hF);
    s_oready = 1'b0;
    for (int i = 0; i < 3; i++) wr(R_TXDATA, 32'hD0 + 32'(i));
    s_ivalid = 1'b1; s_oready = 1'b1;
    wr(R_CTRL, 3);
    idle(1);
    #2;
    apply_reset();
    for (int i = 0; i < 10; i++) peek(i);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      s_ivalid = 1'($urandom_range(0, 1));
      s_idata  = 8'($urandom);
      s_oready = ($urandom_range(0, 3) != 0);
      a    = int'($urandom_range(0, 11));
      kind = int'($urandom_range(0, 3));
      wd   = $urandom;
      case (a)
        R_CTRL: wd = 32'($urandom_range(0, 3))
                   | (($urandom_range(0, 11) == 0) ? 32'h4 : 32'h0)
                   | (($urandom_range(0, 11) == 0) ? 32'h8 : 32'h0);
        R_DIV:   wd = 32'($urandom_range(0, 3));
        R_TXTHR, R_RXTHR: wd = 32'($urandom_range(0, 5));
        default: ;
      endcase
      if ($urandom_range(0, 999) == 0) begin
        idle(1);
        #2;
        apply_reset();
      end else if (kind == 0) wr(a, wd);
      else if (kind == 1)     rd(a);
      else                    peek(a);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpio_stream_ctrl.md
Name: fpio_stream_ctrl

Overview:
Second-generation host-programmable FIFO I/O block. It bridges a word-addressed host register bus to one outbound and one inbound valid/ready byte stream, each buffered by a parametrised FIFO. Over the first-generation block it adds:
- parametrised data width;
- divisor-based outbound pacing;
- enable and flush controls;
- error flags and threshold interrupts.

It sits between the host interconnect and an external serialiser/deserialiser.

Parameters:
FIFO_BITS, 8, log2 of each FIFO depth (depth = 2**FIFO_BITS)
DATA_WIDTH, 8, stream data width (1..32)
ADDR_BITS, 4, host word-address width

Ports:
clk  in  1  clock
rstn  in  1  async active-low reset
irq  out  1  registered interrupt, level
host_addr  in  ADDR_BITS  host word address
host_write_en  in  1  host write strobe, one cycle per access
host_write_data  in  32  host write data
host_read_en  in  1  host read strobe, one cycle per access
host_read_data  out  32  combinational read data for host_addr
dat_o_data  out  DATA_WIDTH  outbound data
dat_o_valid  out  1  outbound valid
dat_o_ready  in  1  outbound ready
dat_i_data  in  DATA_WIDTH  inbound data
dat_i_valid  in  1  inbound valid
dat_i_ready  out  1  inbound ready

Behaviour:
- Clock and reset: single clock clk. Reset rstn is asynchronous and active-low.
- Reset state:
  - both FIFOs empty; all registers 0;
  - irq=0, dat_o_valid=0, dat_i_ready=0 (rx_en=0).
- Register map (word addresses). Unmapped addresses read 0; writes to them are ignored.
  - 0 TXDATA: W pushes write_data[DATA_WIDTH-1:0]. R returns 0.
  - 1 TXFREE: R returns free TX slots, FIFO_BITS+1 bits, zero-extended.
  - 2 RXDATA: R returns the RX head, zero-extended. The pop happens at the clock edge of the read_en cycle.
  - 3 RXCOUNT: R returns RX occupancy.
  - 4 CTRL: bit0 tx_en, bit1 rx_en (RW). bit2 tx_flush, bit3 rx_flush are write-1 pulses that read as 0.
  - 5 DIVISOR: RW, 16 bits.
  - 6 STATUS: bits[1:0] are sticky error flags, write-1-to-clear. bits[3:2] are read-only levels.
    - bit0 tx_ovf: host push while TX full; data dropped.
    - bit1 rx_unf: host RXDATA read while RX empty; returns 0, no pointer change.
    - bit2 tx_low: TX count <= TXTHR.
    - bit3 rx_high: RX count >= RXTHR.
  - 7 IRQEN: RW, bits[3:0] mask STATUS.
  - 8 TXTHR: RW, FIFO_BITS+1 bits.
  - 9 RXTHR: RW, FIFO_BITS+1 bits.
- Register writes take effect at the clock edge. Reads are combinational and reflect pre-edge state.
- FIFOs are first-word-fall-through; head data is valid combinationally when non-empty.
- Outbound pacing uses a 16-bit down-counter pace_cnt (reset 0).
  - dat_o_valid = tx_en & !tx_empty & (pace_cnt==0).
  - On dat_o_valid & dat_o_ready: pop TX and load pace_cnt with DIVISOR.
  - Otherwise pace_cnt decrements while non-zero.
  - DIVISOR=0 gives back-to-back transfers. DIVISOR=N gives at most one transfer every N+1 cycles.
  - Clearing tx_en deasserts valid next cycle. A transfer already accepted is complete.
- Inbound:
  - dat_i_ready = rx_en & !rx_full.
  - Push on dat_i_valid & dat_i_ready.
- Simultaneous events:
  - push+pop on the same FIFO in the same cycle: both occur, count unchanged. Full/empty are judged on pre-edge state, so a host push on a full TX is dropped even if the stream pops in that cycle.
  - Flush wins over push/pop in the same cycle: pointers reset, and pace_cnt also clears on tx_flush.
  - W1C clear and new error set in the same cycle: set wins.
- Counts: FIFO_BITS+1 bits, range 0..2**FIFO_BITS. Pointers wrap modulo depth.
- irq: register = |(STATUS[3:0] & IRQEN[3:0]), one-cycle latency.
- Reset asserted mid-transfer: immediate clear of everything; no partial beat is retained.

Decomposition:
- Package fpio_stream_pkg holds:
  - register address localparams;
  - CTRL/STATUS bit-index constants;
  - a typedef for the STATUS vector.
- Sub-module fpio_sync_fifo: FWFT, parameters FIFO_BITS and DATA_WIDTH, with push, pop, flush, data out, count, full and empty. It is instantiated twice.

Test Plan:
- Basic TX, back-to-back: CTRL=1, DIVISOR=0, push 0x11,0x22,0x33, dat_o_ready=1 -> three beats on consecutive cycles in order; TXFREE returns 256 afterwards.
- Pacing: DIVISOR=3, push 4 bytes, ready=1 -> beats exactly 4 cycles apart; DIVISOR=0 mid-stream -> gap collapses after the current countdown.
- TX overflow: FIFO_BITS=2, tx_en=0, push 5 bytes -> TXFREE=0, STATUS bit0=1, fifth byte absent on drain; write STATUS=1 -> bit0 clears.
- RX path and underflow: rx_en=1, drive 0xA5,0x5A -> RXCOUNT=2, reads return 0xA5 then 0x5A; third read returns 0 with rx_unf=1; with RX full, dat_i_ready=0.
- Interrupts: RXTHR=2, IRQEN=8 -> irq rises the cycle after the 2nd inbound beat and falls after the pops bring count below 2; TXTHR=0, IRQEN=4 -> irq when TX drains empty.
- Flush/reset: fill TX with 3 bytes, write CTRL with tx_flush while ready=1 -> TXFREE=full next cycle, no further beats; assert rstn mid-stream -> all outputs 0 asynchronously.
